// File: rtl/alu8_pkg.sv
// Shared definitions for the 8-bit ALU response checker.
// Contents:
//   ALU8_W       default operand/result width
//   alu8_op_e    opcodes AND..SUB (6 and 7 are unsupported)
//   chk_state_e  checker FSM state encoding
//   op_supported helper predicate for opcode legality
package alu8_pkg;

  localparam int unsigned ALU8_W = 8;

  typedef enum logic [2:0] {
    ALU8_OP_AND  = 3'd0,
    ALU8_OP_OR   = 3'd1,
    ALU8_OP_XOR  = 3'd2,
    ALU8_OP_XNOR = 3'd3,
    ALU8_OP_ADD  = 3'd4,
    ALU8_OP_SUB  = 3'd5
  } alu8_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } chk_state_e;

  function automatic logic op_supported(logic [2:0] op);
    return op <= ALU8_OP_SUB;
  endfunction

endpackage

// File: rtl/alu8_ref_model.sv
// Combinational expected-result model of the 8-bit ALU.
// Ports:
//   op     opcode (alu8_op_e encoding); unsupported codes yield 0
//   a, b   operands
//   exp_z  expected ALU result, ADD/SUB wrap modulo 2^WIDTH
module alu8_ref_model
  import alu8_pkg::*;
#(
  parameter int unsigned WIDTH = ALU8_W
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_z
);

  always_comb begin
    exp_z = '0;
    case (op)
      ALU8_OP_AND:  exp_z = a & b;
      ALU8_OP_OR:   exp_z = a | b;
      ALU8_OP_XOR:  exp_z = a ^ b;
      ALU8_OP_XNOR: exp_z = ~(a ^ b);
      ALU8_OP_ADD:  exp_z = a + b;
      ALU8_OP_SUB:  exp_z = a - b;
      default:      exp_z = '0;
    endcase
  end

endmodule

// File: rtl/alu8_result_checker.sv
// Response checker for the 8-bit ALU datapath. Accepts (a, b, z) triples over
// valid/ready, recomputes the expected z for the latched op and tallies
// pass/fail counts over num_vec vectors.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, op, num_vec    run launch (accepted in IDLE/DONE only)
//   in_valid, in_ready    triple handshake
//   in_a, in_b, in_z      operands and ALU result under test
//   busy, done, op_err    status (RUN, DONE, aborted on unsupported op)
//   pass_cnt, fail_cnt    per-run tallies
// Optional: define ALU8_CHK_MISMATCH_LOG_EN to add first-mismatch capture
//   (fail_seen, fail_idx, fail_a, fail_b, fail_z, fail_exp).
module alu8_result_checker
  import alu8_pkg::*;
#(
  parameter int unsigned WIDTH = ALU8_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_z,
  output logic             busy,
  output logic             done,
  output logic             op_err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef ALU8_CHK_MISMATCH_LOG_EN
  ,
  output logic             fail_seen,
  output logic [CNT_W-1:0] fail_idx,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_z,
  output logic [WIDTH-1:0] fail_exp
`endif
);

  chk_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             op_err_q, op_err_d;

  logic [WIDTH-1:0] exp_z;
  logic             start_ok;
  logic             hs;
  logic             match;

  alu8_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .op    (op_q),
    .a     (in_a),
    .b     (in_b),
    .exp_z (exp_z)
  );

  assign start_ok = start && (state_q != StRun);
  assign hs       = in_valid && (state_q == StRun);
  assign match    = (in_z == exp_z);

`ifdef ALU8_CHK_MISMATCH_LOG_EN
  logic             fseen_q, fseen_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fz_q, fz_d, fexp_q, fexp_d;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    num_vec_d = num_vec_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    op_err_d  = op_err_q;
`ifdef ALU8_CHK_MISMATCH_LOG_EN
    fseen_d   = fseen_q;
    fidx_d    = fidx_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    fz_d      = fz_q;
    fexp_d    = fexp_q;
`endif

    if (start_ok) begin
      pass_d = '0;
      fail_d = '0;
      idx_d  = '0;
`ifdef ALU8_CHK_MISMATCH_LOG_EN
      fseen_d = 1'b0;
      fidx_d  = '0;
      fa_d    = '0;
      fb_d    = '0;
      fz_d    = '0;
      fexp_d  = '0;
`endif
      // An illegal op aborts even when num_vec is also zero.
      if (!op_supported(op)) begin
        state_d  = StDone;
        op_err_d = 1'b1;
      end else if (num_vec == '0) begin
        state_d  = StDone;
        op_err_d = 1'b0;
      end else begin
        state_d   = StRun;
        op_err_d  = 1'b0;
        op_d      = op;
        num_vec_d = num_vec;
      end
    end else if (hs) begin
      if (match) begin
        pass_d = pass_q + CNT_W'(1);
      end else begin
        fail_d = fail_q + CNT_W'(1);
`ifdef ALU8_CHK_MISMATCH_LOG_EN
        if (!fseen_q) begin
          fseen_d = 1'b1;
          fidx_d  = idx_q;
          fa_d    = in_a;
          fb_d    = in_b;
          fz_d    = in_z;
          fexp_d  = exp_z;
        end
`endif
      end
      idx_d = idx_q + CNT_W'(1);
      if (idx_q == num_vec_q - CNT_W'(1)) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      num_vec_q <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      op_err_q  <= 1'b0;
`ifdef ALU8_CHK_MISMATCH_LOG_EN
      fseen_q   <= 1'b0;
      fidx_q    <= '0;
      fa_q      <= '0;
      fb_q      <= '0;
      fz_q      <= '0;
      fexp_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      num_vec_q <= num_vec_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      op_err_q  <= op_err_d;
`ifdef ALU8_CHK_MISMATCH_LOG_EN
      fseen_q   <= fseen_d;
      fidx_q    <= fidx_d;
      fa_q      <= fa_d;
      fb_q      <= fb_d;
      fz_q      <= fz_d;
      fexp_q    <= fexp_d;
`endif
    end
  end

  // Status flags decode the registered state directly.
  assign in_ready = (state_q == StRun);
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign op_err   = op_err_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

`ifdef ALU8_CHK_MISMATCH_LOG_EN
  assign fail_seen = fseen_q;
  assign fail_idx  = fidx_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_z    = fz_q;
  assign fail_exp  = fexp_q;
`endif

endmodule

// File: tb/tb_alu8_result_checker.sv
// Self-checking bench for alu8_result_checker: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_alu8_result_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b, in_z;
  logic             busy, done, op_err;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
`ifdef ALU8_CHK_MISMATCH_LOG_EN
  logic             fail_seen;
  logic [CNT_W-1:0] fail_idx;
  logic [WIDTH-1:0] fail_a, fail_b, fail_z, fail_exp;
`endif

  alu8_result_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .num_vec   (num_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_z      (in_z),
    .busy      (busy),
    .done      (done),
    .op_err    (op_err),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
`ifdef ALU8_CHK_MISMATCH_LOG_EN
    ,
    .fail_seen (fail_seen),
    .fail_idx  (fail_idx),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_z    (fail_z),
    .fail_exp  (fail_exp)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ALU result from plain integer arithmetic.
  function automatic int ref_res(input int o, input int a, input int b);
    case (o)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      3:       return 255 - (a ^ b);
      4:       return (a + b) % 256;
      5:       return (a - b + 256) % 256;
      default: return 0;
    endcase
  endfunction

  // Behavioural model: phase 0 idle, 1 running, 2 finished.
  bit m_live = 1'b0;
  int m_phase, m_rem, m_nv, m_op, m_pass, m_fail, m_err, hs_cnt = 0;
  int m_fseen, m_fidx, m_fa, m_fb, m_fz, m_fexp;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (rst) begin
      m_phase = 0; m_pass = 0; m_fail = 0; m_err = 0; m_rem = 0;
      m_fseen = 0; m_fidx = 0; m_fa = 0; m_fb = 0; m_fz = 0; m_fexp = 0;
    end else if (start && m_phase != 1) begin
      m_pass = 0; m_fail = 0;
      m_fseen = 0; m_fidx = 0; m_fa = 0; m_fb = 0; m_fz = 0; m_fexp = 0;
      if (op > 3'd5) begin
        m_phase = 2; m_err = 1;
      end else if (num_vec == 0) begin
        m_phase = 2; m_err = 0;
      end else begin
        m_phase = 1; m_err = 0; m_rem = int'(num_vec); m_nv = int'(num_vec); m_op = int'(op);
      end
    end else if (m_phase == 1 && in_valid) begin
      int e;
      hs_cnt++;
      e = ref_res(m_op, int'(in_a), int'(in_b));
      if (int'(in_z) == e) m_pass++;
      else begin
        m_fail++;
        if (m_fseen == 0) begin
          m_fseen = 1; m_fidx = m_nv - m_rem;
          m_fa = int'(in_a); m_fb = int'(in_b); m_fz = int'(in_z); m_fexp = e;
        end
      end
      m_rem--;
      if (m_rem == 0) m_phase = 2;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 1));
      check("busy", 32'(busy), 32'(m_phase == 1));
      check("done", 32'(done), 32'(m_phase == 2));
      check("op_err", 32'(op_err), m_err);
      check("pass_cnt", 32'(pass_cnt), m_pass);
      check("fail_cnt", 32'(fail_cnt), m_fail);
`ifdef ALU8_CHK_MISMATCH_LOG_EN
      check("fail_seen", 32'(fail_seen), m_fseen);
      check("fail_idx", 32'(fail_idx), m_fidx);
      check("fail_a", 32'(fail_a), m_fa);
      check("fail_b", 32'(fail_b), m_fb);
      check("fail_z", 32'(fail_z), m_fz);
      check("fail_exp", 32'(fail_exp), m_fexp);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int o, input int nv);
    start   = 1'b1;
    op      = o[2:0];
    num_vec = nv[CNT_W-1:0];
    step();
    start = 1'b0;
  endtask

  // Present one triple and advance past its handshake; in_valid stays high.
  task automatic send(input int a, input int b, input int z);
    int k = 0;
    in_valid = 1'b1;
    in_a = a[WIDTH-1:0];
    in_b = b[WIDTH-1:0];
    in_z = z[WIDTH-1:0];
    while (in_ready !== 1'b1) begin
      step();
      k++;
      if (k > 50) begin
        check("hs_timeout", 32'(in_ready), 32'd1);
        return;
      end
    end
    step();
  endtask

  initial begin
    int h0;
    rst = 1'b1; start = 1'b0; op = '0; num_vec = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_z = '0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // XNOR single vector
    do_start(3, 1);
    check("xnor_ready", 32'(in_ready), 32'd1);
    send(8'h12, 8'h45, 8'hA8);
    in_valid = 1'b0;
    check("xnor_done", 32'(done), 32'd1);
    check("xnor_pass", 32'(pass_cnt), 32'd1);
    check("xnor_fail", 32'(fail_cnt), 32'd0);

    // ADD back-to-back, last one wrong
    do_start(4, 3);
    send(8'hFF, 8'h01, 8'h00);
    send(8'h10, 8'h20, 8'h30);
    send(8'h05, 8'h03, 8'h09);
    in_valid = 1'b0;
    check("add_pass", 32'(pass_cnt), 32'd2);
    check("add_fail", 32'(fail_cnt), 32'd1);
    check("add_done", 32'(done), 32'd1);
`ifdef ALU8_CHK_MISMATCH_LOG_EN
    check("add_fail_idx", 32'(fail_idx), 32'd2);
    check("add_fail_exp", 32'(fail_exp), 32'h08);
`endif

    // SUB with in_valid toggling
    do_start(5, 2);
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      in_valid = i[0];
      in_a = 8'(i * 37 + 11);
      in_b = 8'(i * 13 + 5);
      in_z = 8'(ref_res(5, int'(in_a), int'(in_b)));
      step();
    end
    in_valid = 1'b0;
    check("sub_hs", 32'(hs_cnt - h0), 32'd2);
    check("sub_ready", 32'(in_ready), 32'd0);
    check("sub_pass", 32'(pass_cnt), 32'd2);

    // Unsupported op
    do_start(6, 4);
    check("op6_done", 32'(done), 32'd1);
    check("op6_err", 32'(op_err), 32'd1);
    check("op6_pass", 32'(pass_cnt), 32'd0);
    check("op6_ready", 32'(in_ready), 32'd0);
    step();
    step();

    // num_vec = 0, then a 5-vector run with a start mid-run
    do_start(0, 0);
    check("nv0_done", 32'(done), 32'd1);
    check("nv0_err", 32'(op_err), 32'd0);
    do_start(1, 5);
    send(1, 2, 3);
    send(4, 8, 12);
    start = 1'b1; op = 3'd6; num_vec = '0;
    send(16, 1, 0);
    start = 1'b0;
    send(7, 8, 15);
    send(0, 0, 0);
    in_valid = 1'b0;
    check("run5_total", 32'(pass_cnt) + 32'(fail_cnt), 32'd5);
    check("run5_pass", 32'(pass_cnt), 32'd4);
    check("run5_done", 32'(done), 32'd1);

    // Reset mid-run
    do_start(2, 4);
    send(1, 2, 3);
    send(5, 5, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_pass", 32'(pass_cnt), 32'd0);
    do_start(2, 4);
    send(1, 2, 3);
    check("fresh_pass", 32'(pass_cnt), 32'd1);
    check("fresh_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom % 300) == 0;
      start    = ($urandom % 12) == 0;
      op       = (($urandom % 6) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom % 6);
      num_vec  = CNT_W'($urandom % 7);
      in_valid = ($urandom % 3) != 0;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      in_z     = (($urandom % 4) == 0) ? 8'($urandom)
                                       : 8'(ref_res(m_op, int'(in_a), int'(in_b)));
      step();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu8_result_checker.md
# alu8_result_checker

Synthesizable response checker for the 8-bit ALU datapath. It sits at the output side of an ALU under test, takes operand/result triples over a valid/ready handshake, and recomputes the expected result for a selected operation. It tallies pass/fail counts over a programmed number of vectors, giving on-chip and FPGA self-test the same pass/fail verdict a simulation bench prints.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- CNT_W, 16, width of vector count and pass/fail counters

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a run; honoured only in IDLE or DONE
- op  in  3  operation under check, sampled with start
- num_vec  in  CNT_W  vectors in the run, sampled with start
- in_valid  in  1  triple present
- in_ready  out  1  checker accepts triple
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_z  in  WIDTH  ALU result under test
- busy  out  1  state is RUN
- done  out  1  level, state is DONE
- op_err  out  1  run aborted on unsupported op
- pass_cnt  out  CNT_W  matching vectors
- fail_cnt  out  CNT_W  mismatching vectors

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 ADD (a+b mod 2^WIDTH), 5 SUB (a-b mod 2^WIDTH). 6 and 7 are unsupported.
- States: IDLE, RUN, DONE.
- IDLE → RUN on start with a supported op and num_vec≠0.
  - Latches op and num_vec.
  - Clears pass_cnt, fail_cnt, op_err and the vector index.
- IDLE/DONE → DONE on start with num_vec=0.
  - Counters cleared; op_err=0.
- IDLE/DONE → DONE on start with op 6/7.
  - op_err=1; counters cleared.
- RUN:
  - in_ready=1.
  - A handshake (in_valid & in_ready) compares in_z against the expected value from in_a/in_b.
  - A match increments pass_cnt; a mismatch increments fail_cnt.
  - The index increments on every handshake.
  - The handshake with index = latched num_vec−1 moves the state to DONE.
- DONE:
  - Counters and op_err held; done=1.
  - start begins a new run under the same rules as from IDLE.
- start in RUN is ignored. op and num_vec changes outside a start cycle are ignored.
- Counters cannot overflow: at most num_vec increments, and num_vec < 2^CNT_W.
- Reset values: state IDLE, in_ready 0, busy 0, done 0, op_err 0, pass_cnt 0, fail_cnt 0, index 0.
- rst mid-run discards the run and returns to IDLE with the reset values above.

## Timing
- in_ready, busy and done are registered decodes of state.
- in_ready rises the cycle after the start cycle.
- Compare is combinational on the handshake cycle. The counter update is visible the following cycle (latency 1).
- done rises, and in_ready falls, the cycle after the last handshake. No extra vectors are accepted.
- Back-to-back handshakes at one vector per cycle are sustained.
- in_valid without in_ready (IDLE/DONE) is ignored. The upstream holds its data, no drop.

## Configuration
- ALU8_CHK_MISMATCH_LOG_EN defined adds capture of the first mismatch in a run:
  - Extra outputs: fail_seen (1), fail_idx (CNT_W), fail_a, fail_b, fail_z, fail_exp (WIDTH each).
  - All extra outputs are loaded on the first mismatching handshake and held until the next accepted start or rst, both of which clear them to 0.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

## Structure
- Package alu8_pkg:
  - opcode localparams/enum ALU8_OP_AND..ALU8_OP_SUB.
  - state encoding.
  - ALU8_W default width constant.
- Sub-module alu8_ref_model:
  - Combinational expected-result function of (op, a, b).
  - Reusable by benches and other checkers.
- The checker holds only the FSM, counters and the optional log.

## Test plan
- XNOR, num_vec=1, a=8'b00010010, b=8'b01000101, z=8'b10101000 → pass_cnt=1, fail_cnt=0, done=1 the cycle after the handshake.
- ADD, num_vec=3 back-to-back:
  - Vectors: (0xFF,0x01,z=0x00), (0x10,0x20,z=0x30), (0x05,0x03,z=0x09).
  - Required: pass=2, fail=1.
  - With ALU8_CHK_MISMATCH_LOG_EN: fail_idx=2, fail_exp=0x08.
- SUB, num_vec=2, in_valid toggling every other cycle → exactly 2 handshakes; in_ready=0 after the second.
- start with op=6, num_vec=4 → DONE next cycle, op_err=1, counters 0, in_ready never 1.
- start with num_vec=0 → done=1, counters 0. start again during RUN of a later 5-vector run → ignored, run completes with pass+fail=5.
- rst asserted after 2 of 4 vectors → IDLE, all outputs at reset values. Fresh start with num_vec=4 counts from 0.
